// File: rtl/calc_entry_sequencer.sv
// Calculator entry sequencer: click codes -> operands, operator, ALU start, display value.
// Optional backspace (code 17) is built only when BACKSPACE_EN is defined.
module calc_entry_sequencer #(
  parameter int MAX_DIGITS = 9,
  parameter int TIMEOUT    = 1023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  code,
  input  logic        code_valid,
  input  logic [31:0] alu_result,
  input  logic        alu_done,
  output logic [31:0] num_a,
  output logic [31:0] num_b,
  output logic [1:0]  alu_op,
  output logic        alu_start,
  output logic [31:0] disp_value,
  output logic        busy,
  output logic        error
);
  localparam int CW = $clog2(MAX_DIGITS + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {ENTER_A, ENTER_B, WAIT_ALU, SHOW_RESULT} state_t;

  typedef struct packed {
    logic          sign;
    logic [29:0]   mag;
    logic [CW-1:0] cnt;
  } operand_t;

  state_t        state, state_n;
  operand_t      a, a_n, b, b_n;
  logic [31:0]   result, result_n, disp_n;
  logic [TW-1:0] timer, timer_n;
  logic [1:0]    op_n;
  logic          start_n, error_n;

  function automatic operand_t push_digit(operand_t o, logic [3:0] d);
    operand_t r = o;
    if (o.cnt < CW'(MAX_DIGITS) && !(o.mag == '0 && d == 4'd0)) begin
      r.mag = o.mag * 30'd10 + 30'(d);
      r.cnt = o.cnt + 1'b1;
    end
    return r;
  endfunction

  function automatic operand_t toggle_sign(operand_t o);
    operand_t r = o;
    if (o.mag != '0) r.sign = ~o.sign;
    return r;
  endfunction

  // A loaded result counts as a full operand, so no digits get appended to it.
  function automatic operand_t from_result(logic [31:0] v);
    operand_t    r;
    logic [31:0] abs_v = v[31] ? -v : v;
    r.mag  = abs_v[29:0];
    r.sign = v[31] && (abs_v[29:0] != '0);
    r.cnt  = CW'(MAX_DIGITS);
    return r;
  endfunction

`ifdef BACKSPACE_EN
  function automatic operand_t drop_digit(operand_t o);
    operand_t r = o;
    r.mag = o.mag / 30'd10;
    if (o.cnt != '0) r.cnt = o.cnt - 1'b1;
    if (r.mag == '0) r.sign = 1'b0;
    return r;
  endfunction
`endif

  function automatic logic [31:0] to_value(operand_t o);
    logic [31:0] m = {2'b00, o.mag};
    return o.sign ? -m : m;
  endfunction

  logic       is_digit, is_op;
  logic [1:0] code_op;

  assign is_digit = code <= 5'd9;
  assign is_op    = code >= 5'd10 && code <= 5'd13;
  assign code_op  = 2'(code - 5'd10);

  always_comb begin
    a_n      = a;
    b_n      = b;
    result_n = result;
    op_n     = alu_op;
    state_n  = state;
    start_n  = 1'b0;
    timer_n  = timer;
    error_n  = error;
    if (code_valid && code == 5'd15) begin
      a_n      = '0;
      b_n      = '0;
      result_n = '0;
      op_n     = '0;
      state_n  = ENTER_A;
      timer_n  = '0;
      error_n  = 1'b0;
    end else begin
      case (state)
        ENTER_A: if (code_valid) begin
          if (is_digit) a_n = push_digit(a, code[3:0]);
          else if (code == 5'd16) a_n = toggle_sign(a);
          else if (is_op) begin
            op_n    = code_op;
            b_n     = '0;
            state_n = ENTER_B;
          end
`ifdef BACKSPACE_EN
          else if (code == 5'd17) a_n = drop_digit(a);
`endif
        end
        ENTER_B: if (code_valid) begin
          if (is_digit) b_n = push_digit(b, code[3:0]);
          else if (code == 5'd16) b_n = toggle_sign(b);
          else if (is_op) op_n = code_op;
          else if (code == 5'd14) begin
            start_n = 1'b1;
            timer_n = '0;
            state_n = WAIT_ALU;
          end
`ifdef BACKSPACE_EN
          else if (code == 5'd17) b_n = drop_digit(b);
`endif
        end
        WAIT_ALU: begin
          if (alu_done) begin
            result_n = alu_result;
            state_n  = SHOW_RESULT;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            error_n = 1'b1;
            state_n = ENTER_A;
          end else begin
            timer_n = timer + 1'b1;
          end
        end
        default: if (code_valid) begin
          if (is_digit) begin
            a_n     = push_digit('0, code[3:0]);
            state_n = ENTER_A;
          end else if (is_op) begin
            a_n     = from_result(result);
            op_n    = code_op;
            b_n     = '0;
            state_n = ENTER_B;
          end else if (code == 5'd14) begin
            a_n     = from_result(result);
            start_n = 1'b1;
            timer_n = '0;
            state_n = WAIT_ALU;
          end else if (code == 5'd16) begin
            a_n     = toggle_sign(from_result(result));
            state_n = ENTER_A;
          end
        end
      endcase
    end
    case (state_n)
      ENTER_B:     disp_n = to_value(b_n);
      SHOW_RESULT: disp_n = result_n;
      default:     disp_n = to_value(a_n);
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ENTER_A;
      a          <= '0;
      b          <= '0;
      result     <= '0;
      timer      <= '0;
      num_a      <= '0;
      num_b      <= '0;
      alu_op     <= '0;
      alu_start  <= 1'b0;
      disp_value <= '0;
      busy       <= 1'b0;
      error      <= 1'b0;
    end else begin
      state      <= state_n;
      a          <= a_n;
      b          <= b_n;
      result     <= result_n;
      timer      <= timer_n;
      num_a      <= to_value(a_n);
      num_b      <= to_value(b_n);
      alu_op     <= op_n;
      alu_start  <= start_n;
      disp_value <= disp_n;
      busy       <= (state_n == WAIT_ALU);
      error      <= error_n;
    end
  end
endmodule

// File: tb/tb_calc_entry_sequencer.sv
// Directed bench for calc_entry_sequencer; define BACKSPACE_EN to exercise backspace.
module tb_calc_entry_sequencer;
  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  code;
  logic        code_valid;
  logic [31:0] alu_result;
  logic        alu_done;
  logic [31:0] num_a, num_b, disp_value;
  logic [1:0]  alu_op;
  logic        alu_start, busy, error;

  int errors = 0;
  int checks = 0;

  calc_entry_sequencer #(.MAX_DIGITS(9), .TIMEOUT(1023)) dut (
    .clk(clk), .reset(reset), .code(code), .code_valid(code_valid),
    .alu_result(alu_result), .alu_done(alu_done),
    .num_a(num_a), .num_b(num_b), .alu_op(alu_op), .alu_start(alu_start),
    .disp_value(disp_value), .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, $signed(got), $signed(exp));
    end
  endtask

  task automatic click(input logic [4:0] c);
    @(negedge clk);
    code = c;
    code_valid = 1'b1;
    @(negedge clk);
    code_valid = 1'b0;
  endtask

  task automatic done_pulse(input logic [31:0] v);
    @(negedge clk);
    alu_result = v;
    alu_done = 1'b1;
    @(negedge clk);
    alu_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    reset = 1'b1; code = '0; code_valid = 1'b0; alu_result = '0; alu_done = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_disp", disp_value, 0);
    check("rst_a", num_a, 0);
    check("rst_b", num_b, 0);
    check("rst_op", 32'(alu_op), 0);
    check("rst_start", 32'(alu_start), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_err", 32'(error), 0);

    click(1); click(2); click(3);
    check("a123_disp", disp_value, 123);
    check("a123_a", num_a, 123);

    click(15); click(4); click(5); click(16);
    check("neg45", disp_value, -32'sd45);
    click(10);
    check("opb_disp", disp_value, 0);
    check("opb_op", 32'(alu_op), 0);
    click(6);
    check("b6_disp", disp_value, 6);
    click(14);
    check("eq_start", 32'(alu_start), 1);
    check("eq_busy", 32'(busy), 1);
    check("eq_a", num_a, -32'sd45);
    check("eq_b", num_b, 6);
    check("eq_disp", disp_value, -32'sd45);
    @(negedge clk);
    check("start_1cyc", 32'(alu_start), 0);
    click(5);
    check("wait_ign", disp_value, -32'sd45);
    check("wait_busy", 32'(busy), 1);
    done_pulse(-32'sd39);
    check("res_disp", disp_value, -32'sd39);
    check("res_busy", 32'(busy), 0);

    click(12);
    check("chain_a", num_a, -32'sd39);
    check("chain_op", 32'(alu_op), 2);
    check("chain_disp", disp_value, 0);
    click(2);
    click(14);
    check("chain_start", 32'(alu_start), 1);
    check("chain_b", num_b, 2);

    waited = 0;
    for (int i = 1; i <= 1100; i++) begin
      @(negedge clk);
      waited = i;
      if (!busy) break;
    end
    check("timeout_cycles", 32'(waited), 1023);
    check("timeout_err", 32'(error), 1);
    check("timeout_a", num_a, -32'sd39);
    check("timeout_disp", disp_value, -32'sd39);
    click(15);
    check("clr_err", 32'(error), 0);
    check("clr_a", num_a, 0);
    check("clr_b", num_b, 0);
    check("clr_op", 32'(alu_op), 0);
    check("clr_disp", disp_value, 0);

    click(7); click(10); click(3); click(14);
    done_pulse(10);
    check("show10", disp_value, 10);
    click(14);
    check("rep_start", 32'(alu_start), 1);
    check("rep_a", num_a, 10);
    check("rep_b", num_b, 3);
    done_pulse(13);
    check("show13", disp_value, 13);
    click(16);
    check("neg_res_a", num_a, -32'sd13);
    check("neg_res_disp", disp_value, -32'sd13);
    check("neg_res_busy", 32'(busy), 0);
    done_pulse(77);
    check("done_ignored", disp_value, -32'sd13);

    click(15); click(0);
    repeat (10) click(9);
    check("max_digits", num_a, 999999999);
    click(16);
    check("max_neg", disp_value, -32'sd999999999);
    click(15); click(16);
    check("no_neg_zero", num_a, 0);

    click(15); click(7); click(8); click(9); click(17);
`ifdef BACKSPACE_EN
    check("backspace", disp_value, 78);
`else
    check("backspace", disp_value, 789);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
